// File: rtl/render_pkg.sv
// render_pkg: shared states, pixel/coordinate types and defaults for the render scheduler
package render_pkg;
  localparam int COORD_W = 9;
  localparam int PIX_W = 8;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0] pixel_t;
  localparam pixel_t TRANSPARENT_IDX_DEF = 8'hE3;
  typedef enum logic [2:0] {
    IDLE,
    POS_RUN,
    ENV_RUN,
    SPR_RUN,
    WAIT_VB,
    FLIP
  } rs_state_t;
endpackage

// File: rtl/fb_write_mux.sv
// fb_write_mux: registered frame-buffer write port granted to one engine, dropping transparent sprite pixels
module fb_write_mux
  import render_pkg::*;
#(
  parameter pixel_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   env_gnt_i,
  input  logic   spr_gnt_i,
  input  logic   env_we_i,
  input  coord_t env_x_i,
  input  coord_t env_y_i,
  input  pixel_t env_data_i,
  input  logic   spr_we_i,
  input  coord_t spr_x_i,
  input  coord_t spr_y_i,
  input  pixel_t spr_data_i,
  output logic   fb_we_o,
  output coord_t fb_x_o,
  output coord_t fb_y_o,
  output pixel_t fb_data_o
);
  logic   we_d, we_q;
  coord_t x_d, x_q, y_d, y_q;
  pixel_t data_d, data_q;
  always_comb begin
    we_d   = env_gnt_i ? env_we_i : spr_gnt_i ? (spr_we_i && spr_data_i != TRANSPARENT_IDX) : 1'b0;
    x_d    = !we_d ? x_q : env_gnt_i ? env_x_i : spr_x_i;
    y_d    = !we_d ? y_q : env_gnt_i ? env_y_i : spr_y_i;
    data_d = !we_d ? data_q : env_gnt_i ? env_data_i : spr_data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      x_q    <= x_d;
      y_q    <= y_d;
      data_q <= data_d;
    end
  end
  assign fb_we_o   = we_q;
  assign fb_x_o    = x_q;
  assign fb_y_o    = y_q;
  assign fb_data_o = data_q;
endmodule

// File: rtl/render_scheduler.sv
// render_scheduler: per-frame pos/env/sprite sequencer with vblank page flip; stage watchdog under RENDER_WDT_EN
module render_scheduler
  import render_pkg::*;
#(
  parameter pixel_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
  parameter int     WDT_CYCLES      = 600000,
  parameter int     FRAME_CNT_W     = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   vblank_start,
  output logic                   pos_start,
  input  logic                   pos_done,
  output logic                   env_start,
  input  logic                   env_done,
  output logic                   spr_start,
  input  logic                   spr_done,
  input  logic                   env_we,
  input  coord_t                 env_x,
  input  coord_t                 env_y,
  input  pixel_t                 env_data,
  input  logic                   spr_we,
  input  coord_t                 spr_x,
  input  coord_t                 spr_y,
  input  pixel_t                 spr_data,
  output logic                   fb_we,
  output coord_t                 fb_x,
  output coord_t                 fb_y,
  output pixel_t                 fb_data,
  output logic                   draw_page,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overrun,
  output logic                   wdt_err
);
  rs_state_t state_d, state_q;
  logic entry_q, pos_start_q, env_start_q, spr_start_q, draw_page_q, overrun_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic run, wdt_hit;
  assign run = state_q inside {POS_RUN, ENV_RUN, SPR_RUN};
`ifdef RENDER_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q;
  logic wdt_err_q;
  assign wdt_hit = run && (wdt_q == WDT_W'(WDT_CYCLES - 1));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_q     <= (state_d != state_q) ? '0 : run ? wdt_q + 1'b1 : wdt_q;
      wdt_err_q <= wdt_err_q | wdt_hit;
    end
  end
  assign wdt_err = wdt_err_q;
`else
  assign wdt_hit = 1'b0;
  assign wdt_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = vblank_start ? POS_RUN : IDLE;
      POS_RUN: state_d = (pos_done || wdt_hit) ? ENV_RUN : POS_RUN;
      ENV_RUN: state_d = (env_done || wdt_hit) ? SPR_RUN : ENV_RUN;
      SPR_RUN: state_d = (spr_done || wdt_hit) ? WAIT_VB : SPR_RUN;
      WAIT_VB: state_d = vblank_start ? FLIP : WAIT_VB;
      FLIP:    state_d = POS_RUN;
      default: state_d = IDLE;
    endcase
  end
  // entry_q marks the first cycle in a state; the start pulse follows one edge later
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      entry_q       <= 1'b0;
      pos_start_q   <= 1'b0;
      env_start_q   <= 1'b0;
      spr_start_q   <= 1'b0;
      draw_page_q   <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= state_d != state_q;
      pos_start_q   <= entry_q && state_q == POS_RUN;
      env_start_q   <= entry_q && state_q == ENV_RUN;
      spr_start_q   <= entry_q && state_q == SPR_RUN;
      draw_page_q   <= draw_page_q ^ (state_d == FLIP && state_q == WAIT_VB);
      frame_count_q <= frame_count_q + FRAME_CNT_W'(state_d == FLIP && state_q == WAIT_VB);
      overrun_q     <= overrun_q | (vblank_start && run);
    end
  end
  fb_write_mux #(.TRANSPARENT_IDX(TRANSPARENT_IDX)) u_mux (
    .clk       (Clk),
    .rst       (Reset),
    .env_gnt_i (state_q == ENV_RUN),
    .spr_gnt_i (state_q == SPR_RUN),
    .env_we_i  (env_we),
    .env_x_i   (env_x),
    .env_y_i   (env_y),
    .env_data_i(env_data),
    .spr_we_i  (spr_we),
    .spr_x_i   (spr_x),
    .spr_y_i   (spr_y),
    .spr_data_i(spr_data),
    .fb_we_o   (fb_we),
    .fb_x_o    (fb_x),
    .fb_y_o    (fb_y),
    .fb_data_o (fb_data)
  );
  assign pos_start   = pos_start_q;
  assign env_start   = env_start_q;
  assign spr_start   = spr_start_q;
  assign draw_page   = draw_page_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: scoreboard bench for sequencing, flips, overrun, reset and frame-buffer arbitration
module tb_render_scheduler;
  import render_pkg::*;
  typedef struct packed {coord_t x; coord_t y; pixel_t d;} wr_t;
  logic Clk, Reset, vblank_start, pos_done, env_done, spr_done, env_we, spr_we;
  logic pos_start, env_start, spr_start, fb_we, draw_page, overrun, wdt_err;
  coord_t env_x, env_y, spr_x, spr_y, fb_x, fb_y;
  pixel_t env_data, spr_data, fb_data;
  logic [15:0] frame_count;
  wr_t sb[$];
  wr_t exp_wr;
  pixel_t last_d;
  logic seen;
  int n_tests = 0, n_fail = 0;
  render_scheduler #(.WDT_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset), .vblank_start(vblank_start),
    .pos_start(pos_start), .pos_done(pos_done),
    .env_start(env_start), .env_done(env_done),
    .spr_start(spr_start), .spr_done(spr_done),
    .env_we(env_we), .env_x(env_x), .env_y(env_y), .env_data(env_data),
    .spr_we(spr_we), .spr_x(spr_x), .spr_y(spr_y), .spr_data(spr_data),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .draw_page(draw_page), .frame_count(frame_count),
    .overrun(overrun), .wdt_err(wdt_err)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic env_wr(input coord_t x, input coord_t y, input pixel_t d, input bit push);
    env_we = 1'b1; env_x = x; env_y = y; env_data = d;
    if (push) sb.push_back('{x, y, d});
  endtask
  task automatic spr_wr(input coord_t x, input coord_t y, input pixel_t d, input bit push);
    spr_we = 1'b1; spr_x = x; spr_y = y; spr_data = d;
    if (push && d != 8'hE3) sb.push_back('{x, y, d});
  endtask
  always @(negedge Clk) begin
    if (fb_we === 1'b1) begin
      if (sb.size() == 0) chk("fb_we_unexpected", fb_we, 0);
      else begin
        exp_wr = sb.pop_front();
        chk("fb_write", {fb_x, fb_y, fb_data}, exp_wr);
      end
    end
  end
  initial begin
    Reset = 1'b1; vblank_start = 0; pos_done = 0; env_done = 0; spr_done = 0;
    env_we = 0; env_x = 0; env_y = 0; env_data = 0;
    spr_we = 0; spr_x = 0; spr_y = 0; spr_data = 0;
    repeat (3) tick();
    chk("rst_outputs", {pos_start, env_start, spr_start, fb_we, draw_page, overrun, wdt_err}, 0);
    chk("rst_frame_count", frame_count, 0);
    Reset = 1'b0;
    tick();
    vblank_start = 1; tick(); vblank_start = 0;
    chk("pos_start_edge1", pos_start, 0);
    tick(); chk("pos_start_edge2", pos_start, 1);
    tick(); chk("pos_start_width", pos_start, 0);
    pos_done = 1; tick(); pos_done = 0;
    env_wr(5, 7, 8'h1C, 1); spr_wr(1, 1, 8'h55, 0);
    tick(); chk("env_start", env_start, 1);
    for (int i = 0; i < 8; i++) begin
      env_we = 0;
      if (i % 2 == 0) env_wr(coord_t'($urandom_range(0, 319)), coord_t'($urandom_range(0, 239)), pixel_t'($urandom_range(0, 255)), 1);
      spr_wr(coord_t'(i), coord_t'(i), 8'h66, 0);
      tick();
    end
    last_d = 8'h3A;
    env_wr(20, 30, last_d, 1); env_done = 1; spr_we = 0;
    tick(); env_done = 0;
    chk("spr_start_early", spr_start, 0);
    env_wr(9, 9, 8'h77, 0); spr_wr(2, 2, 8'hE3, 1);
    tick(); env_we = 0;
    chk("spr_start", spr_start, 1);
    chk("fb_we_transparent", fb_we, 0);
    chk("fb_data_hold", fb_data, last_d);
    spr_wr(3, 4, 8'h40, 1);
    tick();
    chk("fb_we_opaque", fb_we, 1);
    chk("fb_data_40", fb_data, 8'h40);
    for (int i = 0; i < 6; i++) begin
      spr_wr(coord_t'($urandom_range(0, 319)), coord_t'($urandom_range(0, 239)), (i == 2) ? 8'hE3 : pixel_t'($urandom_range(0, 255)), 1);
      tick();
    end
    spr_we = 0; spr_done = 1; tick(); spr_done = 0;
    for (int i = 0; i < 4; i++) begin
      env_wr(1, 1, 8'h11, 0); spr_wr(2, 2, 8'h22, 0);
      tick();
    end
    env_we = 0; spr_we = 0;
    chk("page_before_flip", draw_page, 0);
    vblank_start = 1; tick(); vblank_start = 0;
    tick(); chk("pos_start_flip_early", pos_start, 0);
    tick(); chk("pos_start_after_flip", pos_start, 1);
    chk("page_after_flip", draw_page, 1);
    chk("frame_count_1", frame_count, 1);
    chk("no_overrun_yet", overrun, 0);
    env_done = 1; spr_done = 1; tick(); env_done = 0; spr_done = 0;
    tick(); tick();
    chk("done_ignored", {env_start, spr_start}, 0);
    pos_done = 1; tick(); pos_done = 0;
    env_done = 1; tick(); env_done = 0;
    spr_done = 1; vblank_start = 1; tick(); spr_done = 0; vblank_start = 0;
    chk("overrun_set", overrun, 1);
    repeat (5) tick();
    chk("no_tear_page", draw_page, 1);
    chk("no_tear_count", frame_count, 1);
    vblank_start = 1; tick(); vblank_start = 0;
    tick(); tick();
    chk("pos_start_frame3", pos_start, 1);
    chk("page_frame3", draw_page, 0);
    chk("frame_count_2", frame_count, 2);
    pos_done = 1; tick(); pos_done = 0;
    env_wr(4, 4, 8'h99, 0); Reset = 1;
    tick(); Reset = 0; env_we = 0;
    chk("midrst_outputs", {fb_we, draw_page, overrun, wdt_err}, 0);
    chk("midrst_count", frame_count, 0);
    seen = 0;
    pos_done = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pos_done = 0;
      seen |= pos_start | env_start | spr_start;
    end
    chk("no_start_after_rst", seen, 0);
    vblank_start = 1; tick(); vblank_start = 0;
    tick(); chk("pos_start_after_rst", pos_start, 1);
`ifdef RENDER_WDT_EN
    pos_done = 1; tick(); pos_done = 0;
    begin
      int n;
      n = 0;
      while (n < 40 && spr_start !== 1'b1) begin
        tick();
        n++;
      end
      chk("wdt_spr_start_delay", n, 17);
    end
    chk("wdt_err_set", wdt_err, 1);
    Reset = 1; tick(); Reset = 0;
    chk("wdt_err_cleared", wdt_err, 0);
    chk("wdt_rst_page", draw_page, 0);
`else
    repeat (20) tick();
    chk("wdt_err_tied", wdt_err, 0);
`endif
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
